// File: rtl/eco_sweep_ctrl_if.sv
// Host/circuit-side signal bundle for the exhaustive equivalence sweep controller.
// The slave modport is the controller; the master modport is the host plus the two
// circuit instances that answer vec_o with gold_i/rev_i.
interface eco_sweep_ctrl_if #(
  parameter int unsigned NI = 5,
  parameter int unsigned NO = 4
);
  logic          start;
  logic          stop_on_miss;
  logic [NI-1:0] vec_o;
  logic [NO-1:0] gold_i;
  logic [NO-1:0] rev_i;
  logic          busy;
  logic          done;
  logic          equiv;
  logic [NI:0]   miss_cnt;
  logic [NI-1:0] miss_vec;
  logic [NO-1:0] miss_diff;

  modport master (
    output start, stop_on_miss, gold_i, rev_i,
    input  vec_o, busy, done, equiv, miss_cnt, miss_vec, miss_diff
  );

  modport slave (
    input  start, stop_on_miss, gold_i, rev_i,
    output vec_o, busy, done, equiv, miss_cnt, miss_vec, miss_diff
  );
endinterface

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive-sweep equivalence controller: walks all 2^NI input vectors through a golden
// and a revised circuit, compares their outputs OUT_LAT cycles later, and reports the
// mismatch count plus the first failing vector and its difference pattern.
module eco_sweep_ctrl #(
  parameter int unsigned NI      = 5,
  parameter int unsigned NO      = 4,
  parameter int unsigned OUT_LAT = 0
) (
  input logic           clk,
  input logic           rst_n,
  eco_sweep_ctrl_if.slave bus
);

  // Pipeline storage is never zero-width; with OUT_LAT=0 it is simply bypassed.
  localparam int unsigned PL = (OUT_LAT == 0) ? 1 : OUT_LAT;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e        state_q;
  logic          stop_q;
  logic [NI-1:0] vec_q;
  logic          busy_q;
  logic          done_q;
  logic          equiv_q;
  logic [NI:0]   cnt_q;
  logic [NI-1:0] mvec_q;
  logic [NO-1:0] mdiff_q;

  logic [PL-1:0] pv_q;
  logic [NI-1:0] ptag_q [PL];

  logic          issue;
  logic          cmp_valid;
  logic [NI-1:0] cmp_tag;
  logic          miss;
  logic          abort;
  logic          pend;
  logic          last_vec;
  logic          fin;
  logic [NI:0]   cnt_next;

  // Compare point, mismatch detection and sweep-termination decode.
  always_comb begin
    issue = (state_q == StRun);
    if (OUT_LAT == 0) begin
      cmp_valid = issue;
      cmp_tag   = vec_q;
    end else begin
      cmp_valid = pv_q[PL-1];
      cmp_tag   = ptag_q[PL-1];
    end
    miss     = cmp_valid && (bus.gold_i != bus.rev_i);
    abort    = miss && stop_q;
    cnt_next = cnt_q + (NI+1)'(miss);
    // Anything still in flight other than the entry being compared this cycle.
    pend     = |(pv_q & ~(PL'(1) << (PL - 1)));
    last_vec = (vec_q == {NI{1'b1}});
    fin      = 1'b0;
    unique case (state_q)
      StRun:   fin = abort || (last_vec && (OUT_LAT == 0));
      StDrain: fin = abort || !pend;
      default: fin = 1'b0;
    endcase
  end

  // Valid bits of the issued vectors; an abort discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_q <= '0;
    end else if (abort) begin
      pv_q <= '0;
    end else begin
      pv_q[0] <= issue;
      for (int unsigned i = 1; i < PL; i++) begin
        pv_q[i] <= pv_q[i-1];
      end
    end
  end

  // Vector tags travelling alongside the valid bits; data only, no reset needed.
  always_ff @(posedge clk) begin
    ptag_q[0] <= vec_q;
    for (int unsigned i = 1; i < PL; i++) begin
      ptag_q[i] <= ptag_q[i-1];
    end
  end

  // Sweep FSM with registered status, vector and mismatch-capture outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      stop_q  <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equiv_q <= 1'b0;
      cnt_q   <= '0;
      mvec_q  <= '0;
      mdiff_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (miss) begin
        cnt_q <= cnt_next;
        if (cnt_q == '0) begin
          mvec_q  <= cmp_tag;
          mdiff_q <= bus.gold_i ^ bus.rev_i;
        end
      end
      if (fin) begin
        state_q <= StDone;
        done_q  <= 1'b1;
        busy_q  <= 1'b0;
        equiv_q <= (cnt_next == '0);
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              state_q <= StRun;
              stop_q  <= bus.stop_on_miss;
              vec_q   <= '0;
              busy_q  <= 1'b1;
              equiv_q <= 1'b0;
              cnt_q   <= '0;
              mvec_q  <= '0;
              mdiff_q <= '0;
            end
          end
          StRun: begin
            if (last_vec) begin
              state_q <= StDrain;
            end else begin
              vec_q <= vec_q + NI'(1);
            end
          end
          StDrain: state_q <= StDrain;
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.vec_o     = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.equiv     = equiv_q;
  assign bus.miss_cnt  = cnt_q;
  assign bus.miss_vec  = mvec_q;
  assign bus.miss_diff = mdiff_q;

endmodule

// File: tb/tb_eco_sweep_ctrl.sv
// Bench for eco_sweep_ctrl: three instances (OUT_LAT = 0, 1, 2) share host stimulus and
// each answers vec_o through its own circuit model with matching register latency.
module tb_eco_sweep_ctrl;
  localparam int unsigned NI = 5;
  localparam int unsigned NO = 4;
  localparam int NV = 32;
  localparam int NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic stop_on_miss;
  logic [NO-1:0] err_tab [NV];

  logic [NL-1:0][NI-1:0] vec_w;
  logic [NL-1:0]         busy_w;
  logic [NL-1:0]         done_w;
  logic [NL-1:0]         equiv_w;
  logic [NL-1:0][NI:0]   cnt_w;
  logic [NL-1:0][NI-1:0] mvec_w;
  logic [NL-1:0][NO-1:0] mdiff_w;

  function automatic logic [NO-1:0] gold_fn(input logic [NI-1:0] v);
    int x;
    x = (int'(v) * 7) ^ (int'(v) >> 2) ^ 5;
    return x[NO-1:0];
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_inst
    eco_sweep_ctrl_if #(.NI(NI), .NO(NO)) bus ();
    logic [NI-1:0] d1;
    logic [NI-1:0] d2;
    logic [NI-1:0] tap;

    always_ff @(posedge clk) begin
      d1 <= bus.vec_o;
      d2 <= d1;
    end

    assign tap              = (g == 0) ? bus.vec_o : ((g == 1) ? d1 : d2);
    assign bus.start        = start;
    assign bus.stop_on_miss = stop_on_miss;
    assign bus.gold_i       = gold_fn(tap);
    assign bus.rev_i        = gold_fn(tap) ^ err_tab[tap];
    assign vec_w[g]         = bus.vec_o;
    assign busy_w[g]        = bus.busy;
    assign done_w[g]        = bus.done;
    assign equiv_w[g]       = bus.equiv;
    assign cnt_w[g]         = bus.miss_cnt;
    assign mvec_w[g]        = bus.miss_vec;
    assign mdiff_w[g]       = bus.miss_diff;

    eco_sweep_ctrl #(.NI(NI), .NO(NO), .OUT_LAT(g)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  int checks;
  int failures;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d got=%0h want=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          stop;
    logic [NO-1:0] all_mask;
    int          v0;
    logic [NO-1:0] m0;
    int          v1;
    logic [NO-1:0] m1;
    bit          e_equiv;
    int          e_cnt;
    int          e_vec;
    logic [NO-1:0] e_diff;
  } vec_rec_t;

  typedef struct {
    int          done_off;
    int          freeze;
    int          cnt;
    int          fvec;
    logic [NO-1:0] fdiff;
    bit          equiv;
  } exp_t;

  // Outcome of a sweep from the error table alone: which vectors differ, where it stops.
  function automatic exp_t model(input bit stop, input int lat);
    exp_t e;
    int first = -1;
    int n = 0;
    for (int v = 0; v < NV; v++) begin
      if (err_tab[v] != '0) begin
        if (first < 0) first = v;
        n++;
      end
    end
    e.fvec  = (first < 0) ? 0 : first;
    e.fdiff = (first < 0) ? '0 : err_tab[first];
    if (stop && first >= 0) begin
      e.cnt      = 1;
      e.done_off = first + lat + 2;
      e.freeze   = (first + lat > NV - 1) ? NV - 1 : first + lat;
    end else begin
      e.cnt      = n;
      e.done_off = NV + lat + 1;
      e.freeze   = NV - 1;
    end
    e.equiv = (e.cnt == 0);
    return e;
  endfunction

  task automatic set_err(input vec_rec_t r);
    for (int v = 0; v < NV; v++) err_tab[v] = r.all_mask;
    err_tab[r.v0] = err_tab[r.v0] ^ r.m0;
    err_tab[r.v1] = err_tab[r.v1] ^ r.m1;
  endtask

  // Called at a negedge; the next posedge is edge T. Returns one cycle after the last done.
  task automatic run_sweep(input bit stop, input bit use_tab, input vec_rec_t r);
    exp_t e [NL];
    int dmin = 1 << 30;
    int dmax = 0;
    for (int g = 0; g < NL; g++) begin
      e[g] = model(stop, g);
      if (e[g].done_off < dmin) dmin = e[g].done_off;
      if (e[g].done_off > dmax) dmax = e[g].done_off;
    end
    start        = 1'b1;
    stop_on_miss = stop;
    for (int c = 1; c <= dmax + 1; c++) begin
      @(negedge clk);
      for (int g = 0; g < NL; g++) begin
        logic          xb;
        logic          xd;
        logic [NI-1:0] xv;
        xb = (c < e[g].done_off);
        xd = (c == e[g].done_off);
        if (c <= e[g].done_off) xv = NI'((c - 1 < e[g].freeze) ? c - 1 : e[g].freeze);
        else xv = NI'(e[g].freeze);
        check("busy_done_vec", g, 32'({busy_w[g], done_w[g], vec_w[g]}), 32'({xb, xd, xv}));
        if (c == 1) check("cleared_at_start", g, 32'({equiv_w[g], cnt_w[g]}), 32'd0);
        if (c >= e[g].done_off) begin
          check("result", g, 32'({equiv_w[g], cnt_w[g], mvec_w[g], mdiff_w[g]}),
                32'({e[g].equiv, (NI+1)'(e[g].cnt), NI'(e[g].fvec), e[g].fdiff}));
        end
        if (use_tab && c == e[g].done_off) begin
          check("table_result", g, 32'({equiv_w[g], cnt_w[g], mvec_w[g], mdiff_w[g]}),
                32'({r.e_equiv, (NI+1)'(r.e_cnt), NI'(r.e_vec), r.e_diff}));
        end
      end
      // Start pulses while busy or in DONE must be ignored.
      if (c <= dmin) begin
        start        = 1'($urandom_range(0, 1));
        stop_on_miss = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic check_reset(input string name);
    for (int g = 0; g < NL; g++) begin
      check(name, g, 32'({busy_w[g], done_w[g], equiv_w[g], cnt_w[g], vec_w[g], mvec_w[g],
                          mdiff_w[g]}), 32'd0);
    end
  endtask

  vec_rec_t tab [6];
  vec_rec_t none_rec;
  int done_seen [NL];

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    start        = 1'b1;
    stop_on_miss = 1'b0;
    for (int v = 0; v < NV; v++) err_tab[v] = '0;
    none_rec = '{0, 4'h0, 0, 4'h0, 0, 4'h0, 1'b1, 0, 0, 4'h0};

    //          stop all   v0  m0    v1  m1    equiv cnt vec diff
    tab[0] = '{0, 4'h0, 0,  4'h0, 0,  4'h0, 1'b1, 0,  0,  4'h0};
    tab[1] = '{0, 4'h0, 19, 4'h4, 0,  4'h0, 1'b0, 1,  19, 4'h4};
    tab[2] = '{0, 4'hF, 0,  4'h0, 0,  4'h0, 1'b0, 32, 0,  4'hF};
    tab[3] = '{1, 4'h0, 7,  4'h1, 9,  4'h2, 1'b0, 1,  7,  4'h1};
    tab[4] = '{0, 4'h0, 3,  4'h8, 30, 4'h3, 1'b0, 2,  3,  4'h8};
    tab[5] = '{0, 4'h0, 0,  4'h0, 0,  4'h0, 1'b1, 0,  0,  4'h0};

    // Reset with start held high: reset wins.
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check_reset("idle_after_reset");

    // Directed table; consecutive sweeps are back-to-back for the OUT_LAT=2 instance.
    for (int i = 0; i < 6; i++) begin
      set_err(tab[i]);
      run_sweep(tab[i].stop, 1'b1, tab[i]);
    end

    // Mid-sweep reset while vec_o=10, with mismatches already counted.
    for (int v = 0; v < NV; v++) err_tab[v] = 4'hF;
    start        = 1'b1;
    stop_on_miss = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      for (int g = 0; g < NL; g++) begin
        check("pre_reset_vec", g, 32'(vec_w[g]), 32'(c - 1));
        if (c == 11) check("pre_reset_cnt", g, 32'(cnt_w[g]), 32'(10 - g));
      end
      start = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    check_reset("mid_sweep_reset");
    rst_n = 1'b1;
    start = 1'b0;
    for (int g = 0; g < NL; g++) done_seen[g] = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int g = 0; g < NL; g++) if (done_w[g] || busy_w[g]) done_seen[g]++;
    end
    for (int g = 0; g < NL; g++) check("no_done_after_reset", g, 32'(done_seen[g]), 32'd0);

    // Random error tables and stop modes against the reference model.
    for (int t = 0; t < 10; t++) begin
      bit s;
      s = 1'($urandom_range(0, 1));
      for (int v = 0; v < NV; v++) begin
        if (t != 3 && $urandom_range(0, 7) == 0) err_tab[v] = NO'($urandom_range(1, 15));
        else err_tab[v] = '0;
      end
      run_sweep(s, 1'b0, none_rec);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
